// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared encodings for the multi-cycle CPU control unit.
//   * opcode constants (IR[31:26])
//   * FSM state encodings (also visible on the debug state port)
//   * ALUOp, RegDst and PCSrc select encodings
//   * per-instruction select bundle driven by ctrl_decode
//   * op_class(): groups opcodes by the FSM path they take after ID
package ctrl_pkg;

  localparam int ST_BITS  = 4;
  localparam int ALU_BITS = 3;

  // Opcodes
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [ST_BITS-1:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_EXE_LS = 4'b0010,
    S_MEM    = 4'b0011,
    S_WB_LD  = 4'b0100,
    S_EXE_BR = 4'b0101,
    S_EXE_AL = 4'b0110,
    S_WB_AL  = 4'b0111,
    S_HALT   = 4'b1000
  } state_e;

  typedef enum logic [ALU_BITS-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_SLL = 3'b010,
    ALU_OR  = 3'b011,
    ALU_AND = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  // Datapath selects that depend only on the opcode
  typedef struct packed {
    alu_op_e    alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       ext_sel;
    logic [1:0] reg_dst;
    logic       db_data_src;
    logic       wr_reg_d_src;
  } sel_t;

  typedef enum logic [2:0] {
    C_AL,    // ALU op: EXE_AL -> WB_AL
    C_BR,    // conditional branch: EXE_BR
    C_LS,    // load/store: EXE_LS -> MEM (-> WB_LD)
    C_JMP,   // j/jal/jr: retire in ID
    C_HALT,
    C_UNDEF  // treated as NOP, retires in ID
  } op_class_e;

  function automatic op_class_e op_class(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND,
      OP_ORI, OP_SLL, OP_SLT:             return C_AL;
      OP_BEQ, OP_BLTZ:                    return C_BR;
      OP_SW, OP_LW:                       return C_LS;
      OP_J, OP_JR, OP_JAL:                return C_JMP;
      OP_HALT:                            return C_HALT;
      default:                            return C_UNDEF;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational opcode -> per-instruction datapath selects.
//   opcode : IR[31:26]
//   sel    : ALUOp, ALUSrcA/B, ExtSel, RegDst, DBDataSrc, WrRegDSrc
// State gating of these selects is done in the top level.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output sel_t       sel
);

  always_comb begin
    sel              = '0;
    sel.alu_op       = ALU_ADD;
    sel.ext_sel      = 1'b1;
    sel.reg_dst      = RD_RT;
    sel.wr_reg_d_src = 1'b1;
    case (opcode)
      OP_ADD:  sel.reg_dst = RD_RD;
      OP_SUB:  begin sel.alu_op = ALU_SUB; sel.reg_dst = RD_RD; end
      OP_ADDI: sel.alu_src_b = 1'b1;
      OP_OR:   begin sel.alu_op = ALU_OR;  sel.reg_dst = RD_RD; end
      OP_AND:  begin sel.alu_op = ALU_AND; sel.reg_dst = RD_RD; end
      OP_ORI:  begin sel.alu_op = ALU_OR;  sel.alu_src_b = 1'b1; sel.ext_sel = 1'b0; end
      OP_SLL:  begin
        sel.alu_op    = ALU_SLL;
        sel.alu_src_a = 1'b1;
        sel.alu_src_b = 1'b1;
        sel.reg_dst   = RD_RD;
      end
      OP_SLT:  begin sel.alu_op = ALU_SLT; sel.reg_dst = RD_RD; end
      OP_SW:   sel.alu_src_b = 1'b1;
      OP_LW:   begin sel.alu_src_b = 1'b1; sel.db_data_src = 1'b1; end
      OP_BEQ,
      OP_BLTZ: sel.alu_op = ALU_SUB;
      OP_JAL:  begin sel.reg_dst = RD_R31; sel.wr_reg_d_src = 1'b0; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl -- control unit of the multi-cycle CPU.
// Sequences each instruction through IF/ID/EXE/MEM/WB and drives every
// datapath select and write enable combinationally from the current state,
// the opcode and the ALU flags.
//   CLK, Reset      : clock; synchronous active-high reset (forces IF)
//   opcode          : IR[31:26], stable from ID onward
//   zero, sign      : ALU flags, valid in EXE
//   state           : current FSM state (debug)
//   PCWre .. PCSrc  : datapath enables and selects
//   inst_count      : retired instruction counter (only with CTRL_PERF_CNT_EN)
// Optional feature macro: CTRL_PERF_CNT_EN.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 3
)(
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               sign,
  output logic [STATE_W-1:0] state,
  output logic               PCWre,
  output logic               IRWre,
  output logic               InsMemRW,
  output logic               ExtSel,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         RegDst,
  output logic               WrRegDSrc,
  output logic               DBDataSrc,
  output logic               RegWre,
  output logic               mRD,
  output logic               mWR,
  output logic [1:0]         PCSrc
`ifdef CTRL_PERF_CNT_EN
  ,output logic [31:0]       inst_count
`endif
);

  state_e    state_q, state_d, st;
  op_class_e cls;
  sel_t      dec_sel, sel;

  ctrl_decode u_decode (
    .opcode (opcode),
    .sel    (dec_sel)
  );

  assign cls = op_class(opcode);

  // While Reset is held the outputs already show the IF values, so the
  // datapath sees a clean fetch even before the first reset edge.
  assign st = Reset ? S_IF : state_q;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (cls)
          C_BR:    state_d = S_EXE_BR;
          C_LS:    state_d = S_EXE_LS;
          C_HALT:  state_d = S_HALT;
          C_AL:    state_d = S_EXE_AL;
          default: state_d = S_IF;  // jumps and undefined opcodes retire here
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL:  state_d = S_IF;
      S_EXE_BR: state_d = S_IF;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      S_WB_LD:  state_d = S_IF;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Selects read as zero during fetch; the opcode is not yet meaningful.
  always_comb begin
    sel = '0;
    if (st != S_IF) sel = dec_sel;
  end

  always_comb begin
    PCWre  = 1'b0;
    RegWre = 1'b0;
    mRD    = 1'b0;
    mWR    = 1'b0;
    PCSrc  = PC_SEQ;
    case (st)
      S_ID: begin
        if (cls == C_JMP || cls == C_UNDEF) PCWre = 1'b1;
        if (opcode == OP_JAL) RegWre = 1'b1;
        if (opcode == OP_J || opcode == OP_JAL) PCSrc = PC_J;
        else if (opcode == OP_JR)               PCSrc = PC_JR;
      end
      S_EXE_BR: begin
        PCWre = 1'b1;
        if ((opcode == OP_BEQ && zero) || (opcode == OP_BLTZ && sign)) PCSrc = PC_BR;
      end
      S_WB_AL: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      S_MEM: begin
        mRD   = (opcode == OP_LW);
        mWR   = (opcode == OP_SW);
        PCWre = (opcode == OP_SW);
      end
      S_WB_LD: begin
        PCWre  = 1'b1;
        RegWre = 1'b1;
      end
      default: ;
    endcase
  end

  assign state     = STATE_W'(st);
  assign IRWre     = (st == S_IF);
  assign InsMemRW  = 1'b1;
  assign ExtSel    = sel.ext_sel;
  assign ALUSrcA   = sel.alu_src_a;
  assign ALUSrcB   = sel.alu_src_b;
  assign ALUOp     = ALUOP_W'(sel.alu_op);
  assign RegDst    = sel.reg_dst;
  assign WrRegDSrc = sel.wr_reg_d_src;
  assign DBDataSrc = sel.db_data_src;

`ifdef CTRL_PERF_CNT_EN
  // One count per retired instruction; PCWre is never set in HALT.
  logic [31:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (Reset)      cnt_q <= '0;
    else if (PCWre) cnt_q <= cnt_q + 32'd1;
  end
  assign inst_count = cnt_q;
`endif

endmodule
